// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: resets the PLL, waits for a stable lock, then releases the
// downstream reset, and checks the PLL output frequency against a legal window.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 64,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned WINDOW        = 1000,
    parameter int unsigned FREQ_MIN      = 90,
    parameter int unsigned FREQ_MAX      = 110
) (
    input  logic        clk_tb,
    input  logic        rst_n,
    input  logic        pll_lock,
    input  logic        clk_mon,
    output logic        pll_rst,
    output logic        sys_rst_n,
    output logic [2:0]  state,
    output logic [1:0]  retry_cnt,
    output logic [7:0]  loss_cnt,
    output logic [15:0] freq_cnt,
    output logic        freq_valid,
    output logic        freq_err,
    output logic        fail
);

    localparam int unsigned CNT_MAX =
        (LOCK_TIMEOUT > RST_CYCLES)
            ? ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES)
            : ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES);
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned WIN_W = $clog2(WINDOW + 1);

    localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WinLast    = WIN_W'(WINDOW - 1);
    localparam logic [1:0]       RetryLast  = 2'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StResetPll = 3'd1,
        StWaitLock = 3'd2,
        StStable   = 3'd3,
        StRun      = 3'd4,
        StFail     = 3'd5
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       retry_q;
    logic [7:0]       loss_q;
    logic             pll_rst_q, sys_rst_n_q, fail_q;

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic [1:0]       lock_sync_q, mon_sync_q;
    logic             lock_s, mon_s, mon_prev_q, mon_rise;

    logic [WIN_W-1:0] win_q;
    logic [15:0]      edge_q, edge_sum, freq_cnt_q;
    logic             freq_valid_q, freq_err_q, win_ok_q, win_ok_now, out_of_range;

    // Reset asserts asynchronously, releases two clk_tb edges later.
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    always_ff @(posedge clk_tb or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lock_sync_q <= 2'b00;
            mon_sync_q  <= 2'b00;
            mon_prev_q  <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_lock};
            mon_sync_q  <= {mon_sync_q[0], clk_mon};
            mon_prev_q  <= mon_s;
        end
    end
    assign lock_s   = lock_sync_q[1];
    assign mon_s    = mon_sync_q[1];
    assign mon_rise = mon_s & ~mon_prev_q;

    always_ff @(posedge clk_tb or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            retry_q     <= 2'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q   <= StResetPll;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                end
                StResetPll: begin
                    if (cnt_q == RstLast) begin
                        state_q   <= StWaitLock;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StWaitLock: begin
                    if (lock_s) begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end else if (cnt_q == TimeoutLast) begin
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q == RetryLast) begin
                            state_q <= StFail;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= StResetPll;
                            retry_q <= retry_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StStable: begin
                    // Any dropout restarts both the stability count and the timeout budget.
                    if (!lock_s) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q == StableLast) begin
                        state_q     <= StRun;
                        cnt_q       <= '0;
                        retry_q     <= 2'd0;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_q     <= StResetPll;
                        cnt_q       <= '0;
                        retry_q     <= 2'd0;
                        sys_rst_n_q <= 1'b0;
                        pll_rst_q   <= 1'b1;
                        if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
                    end
                end
                StFail: begin
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    fail_q      <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    fail_q      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        edge_sum = edge_q;
        if (mon_rise && (edge_q != 16'hFFFF)) edge_sum = edge_q + 16'd1;
        out_of_range = (edge_sum < 16'(FREQ_MIN)) || (edge_sum > 16'(FREQ_MAX));
        // A window is judged only if every one of its cycles was spent in RUN.
        win_ok_now = win_ok_q && (state_q == StRun);
    end

    always_ff @(posedge clk_tb or negedge rst_int_n) begin
        if (!rst_int_n) begin
            win_q        <= '0;
            edge_q       <= 16'd0;
            freq_cnt_q   <= 16'd0;
            freq_valid_q <= 1'b0;
            freq_err_q   <= 1'b0;
            win_ok_q     <= 1'b0;
        end else if (win_q == WinLast) begin
            win_q        <= '0;
            edge_q       <= 16'd0;
            freq_cnt_q   <= edge_sum;
            freq_valid_q <= 1'b1;
            win_ok_q     <= 1'b1;
            if (win_ok_now && out_of_range) freq_err_q <= 1'b1;
        end else begin
            win_q        <= win_q + WIN_W'(1);
            edge_q       <= edge_sum;
            freq_valid_q <= 1'b0;
            win_ok_q     <= win_ok_now;
        end
    end

    assign state      = state_q;
    assign retry_cnt  = retry_q;
    assign loss_cnt   = loss_q;
    assign pll_rst    = pll_rst_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign fail       = fail_q;
    assign freq_cnt   = freq_cnt_q;
    assign freq_valid = freq_valid_q;
    assign freq_err   = freq_err_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: lock sequencing, retries, lock loss,
// glitch handling, frequency windows and asynchronous reset.
module tb_pll_lock_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_RESET_PLL = 3'd1, S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_STABLE = 3'd3, S_RUN = 3'd4, S_FAIL = 3'd5;

    logic        clk_tb = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_lock = 1'b0;
    logic        clk_mon = 1'b0;
    logic        pll_rst, sys_rst_n, freq_valid, freq_err, fail;
    logic [2:0]  state;
    logic [1:0]  retry_cnt;
    logic [7:0]  loss_cnt;
    logic [15:0] freq_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int mon_period = 10;
    bit inv_en = 1'b0;

    typedef struct {
        int period;
        int skip;
        int windows;
        int exp_cnt;
        int exp_err;
    } freq_vec_t;

    typedef struct {
        int cnt;
        int err;
    } freq_exp_t;

    freq_vec_t fvec[3];
    freq_exp_t exp_q[$];

    pll_lock_sequencer dut (
        .clk_tb     (clk_tb),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .clk_mon    (clk_mon),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .freq_cnt   (freq_cnt),
        .freq_valid (freq_valid),
        .freq_err   (freq_err),
        .fail       (fail)
    );

    always #5 clk_tb = ~clk_tb;

    initial begin
        forever begin
            repeat (mon_period / 2) @(posedge clk_tb);
            #2 clk_mon = ~clk_mon;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Output relations that must hold on every cycle.
    always @(negedge clk_tb) begin
        if (inv_en) begin
            check("inv sys_rst_n", int'(sys_rst_n), int'(state == S_RUN));
            check("inv fail", int'(fail), int'(state == S_FAIL));
            check("inv pll_rst", int'(pll_rst),
                  int'(state == S_IDLE || state == S_RESET_PLL || state == S_FAIL));
        end
    end

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (state != st && n < budget) begin
            @(negedge clk_tb);
            n++;
        end
        check(name, int'(state), int'(st));
    endtask

    task automatic count_state(input logic [2:0] st, input int cap, output int n);
        n = 0;
        while (state == st && n < cap) begin
            n++;
            @(negedge clk_tb);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk_tb);
        while (!freq_valid && n < 1100) begin
            @(negedge clk_tb);
            n++;
        end
        check(name, int'(freq_valid), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " state"}, int'(state), int'(S_IDLE));
        check({tag, " pll_rst"}, int'(pll_rst), 1);
        check({tag, " sys_rst_n"}, int'(sys_rst_n), 0);
        check({tag, " retry_cnt"}, int'(retry_cnt), 0);
        check({tag, " loss_cnt"}, int'(loss_cnt), 0);
        check({tag, " freq_cnt"}, int'(freq_cnt), 0);
        check({tag, " freq_valid"}, int'(freq_valid), 0);
        check({tag, " freq_err"}, int'(freq_err), 0);
        check({tag, " fail"}, int'(fail), 0);
    endtask

    initial begin
        int n;
        freq_exp_t e;

        fvec[0] = '{period: 10, skip: 2, windows: 2, exp_cnt: 100, exp_err: 0};
        fvec[1] = '{period: 8,  skip: 2, windows: 2, exp_cnt: 125, exp_err: 1};
        fvec[2] = '{period: 10, skip: 2, windows: 1, exp_cnt: 100, exp_err: 1};

        repeat (5) @(negedge clk_tb);
        check_reset("reset");
        rst_n = 1'b1;
        inv_en = 1'b1;

        // Lock arrives 500 cycles after the PLL reset pulse and holds.
        wait_state(S_RESET_PLL, 10, "reach RESET_PLL");
        count_state(S_RESET_PLL, 100, n);
        check("first pll_rst pulse length", n, 16);
        check("after RESET_PLL", int'(state), int'(S_WAIT_LOCK));
        repeat (499) @(negedge clk_tb);
        pll_lock = 1'b1;
        wait_state(S_STABLE, 10, "lock -> STABLE");
        count_state(S_STABLE, 200, n);
        check("STABLE length", n, 64);
        check("STABLE -> RUN", int'(state), int'(S_RUN));
        check("RUN sys_rst_n", int'(sys_rst_n), 1);
        check("RUN retry_cnt", int'(retry_cnt), 0);

        // Lock drops for 10 cycles in RUN.
        pll_lock = 1'b0;
        fork
            begin
                repeat (10) @(negedge clk_tb);
                pll_lock = 1'b1;
            end
        join_none
        n = 0;
        while (sys_rst_n && n < 10) begin
            @(negedge clk_tb);
            n++;
        end
        check("sys_rst_n drop within 3", int'(n >= 1 && n <= 3), 1);
        check("loss -> RESET_PLL", int'(state), int'(S_RESET_PLL));
        check("loss_cnt after drop", int'(loss_cnt), 1);
        count_state(S_RESET_PLL, 100, n);
        check("recovery pll_rst pulse length", n, 16);
        wait_state(S_RUN, 200, "recover to RUN");
        check("loss_cnt after recovery", int'(loss_cnt), 1);
        check("retry_cnt after recovery", int'(retry_cnt), 0);

        // One-cycle lock glitch at STABLE cycle 30.
        pll_lock = 1'b0;
        wait_state(S_WAIT_LOCK, 100, "drop -> WAIT_LOCK");
        pll_lock = 1'b1;
        wait_state(S_STABLE, 10, "relock -> STABLE");
        repeat (29) @(negedge clk_tb);
        pll_lock = 1'b0;
        @(negedge clk_tb);
        pll_lock = 1'b1;
        wait_state(S_WAIT_LOCK, 5, "glitch -> WAIT_LOCK");
        wait_state(S_STABLE, 5, "glitch recovery -> STABLE");
        count_state(S_STABLE, 200, n);
        check("STABLE length after glitch", n, 64);
        check("glitch recovery RUN", int'(state), int'(S_RUN));
        check("loss_cnt after glitch test", int'(loss_cnt), 2);

        // Frequency windows in RUN.
        for (int i = 0; i < 3; i++) begin
            mon_period = fvec[i].period;
            for (int s = 0; s < fvec[i].skip; s++) wait_valid("freq flush valid");
            for (int w = 0; w < fvec[i].windows; w++)
                exp_q.push_back('{cnt: fvec[i].exp_cnt, err: fvec[i].exp_err});
            for (int w = 0; w < fvec[i].windows; w++) begin
                wait_valid("freq_valid");
                e = exp_q.pop_front();
                check($sformatf("freq_cnt period %0d", fvec[i].period), int'(freq_cnt), e.cnt);
                check($sformatf("freq_err period %0d", fvec[i].period), int'(freq_err), e.err);
                @(negedge clk_tb);
                check("freq_valid one cycle", int'(freq_valid), 0);
            end
        end
        check("still RUN after freq test", int'(state), int'(S_RUN));

        // Asynchronous reset in RUN.
        @(negedge clk_tb);
        #2 rst_n = 1'b0;
        #1 check_reset("async reset");
        repeat (3) @(negedge clk_tb);
        check_reset("held reset");
        rst_n = 1'b1;
        wait_state(S_RESET_PLL, 10, "restart RESET_PLL");
        wait_state(S_RUN, 200, "restart RUN");
        check("loss_cnt after restart", int'(loss_cnt), 0);
        check("freq_err after restart", int'(freq_err), 0);

        // Lock lost and never returns: three timeouts then FAIL.
        pll_lock = 1'b0;
        wait_state(S_RESET_PLL, 10, "timeout test RESET_PLL");
        check("loss_cnt before timeouts", int'(loss_cnt), 1);
        for (int a = 0; a < 3; a++) begin
            wait_state(S_RESET_PLL, 10, $sformatf("attempt %0d RESET_PLL", a));
            check($sformatf("attempt %0d retry_cnt", a), int'(retry_cnt), a);
            count_state(S_RESET_PLL, 100, n);
            check($sformatf("attempt %0d pll_rst length", a), n, 16);
            count_state(S_WAIT_LOCK, 10000, n);
            check($sformatf("attempt %0d timeout length", a), n, 4096);
        end
        check("FAIL state", int'(state), int'(S_FAIL));
        check("FAIL fail", int'(fail), 1);
        check("FAIL retry_cnt", int'(retry_cnt), 2);
        check("FAIL pll_rst", int'(pll_rst), 1);
        check("FAIL sys_rst_n", int'(sys_rst_n), 0);
        pll_lock = 1'b1;
        repeat (100) @(negedge clk_tb);
        check("FAIL terminal", int'(state), int'(S_FAIL));

        inv_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: clk_tb cycles pll_rst is held high per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT_LOCK before a retry.
REQ-003 SHALL have parameter STABLE_CYCLES, default 64: consecutive synchronized-lock cycles required before release.
REQ-004 SHALL have parameter MAX_RETRY, default 3: failed attempts tolerated before FAIL.
REQ-005 SHALL have parameter WINDOW, default 1000: clk_tb cycles per frequency measurement window.
REQ-006 SHALL have parameters FREQ_MIN, default 90, and FREQ_MAX, default 110: inclusive legal edge-count range per window.
REQ-007 clk_tb  input  1  sequencer clock.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 pll_lock  input  1  PLL lock, asynchronous to clk_tb.
REQ-010 clk_mon  input  1  PLL output under measurement, asynchronous, frequency below clk_tb/4.
REQ-011 pll_rst  output  1  PLL reset request, active-high.
REQ-012 sys_rst_n  output  1  downstream reset, active-low, deasserted only in RUN.
REQ-013 state  output  3  encoding: IDLE=0, RESET_PLL=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5.
REQ-014 retry_cnt  output  2  failed attempts in the current sequence.
REQ-015 loss_cnt  output  8  lock-loss events in RUN, saturating at 255.
REQ-016 freq_cnt  output  16  clk_mon rising edges counted in the last completed window.
REQ-017 freq_valid  output  1  one-cycle pulse when freq_cnt updates.
REQ-018 freq_err  output  1  sticky; set when a RUN window count is outside [FREQ_MIN, FREQ_MAX].
REQ-019 fail  output  1  high while in FAIL.

Function
REQ-020 pll_lock and clk_mon SHALL each pass through a 2-flop synchronizer; all decisions use the synchronized values (lock_s, mon_s).
REQ-021 IDLE SHALL last exactly one cycle after reset release, then go to RESET_PLL.
REQ-022 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with pll_rst=0 and a cleared cycle counter.
REQ-023 WAIT_LOCK: lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> retry (REQ-026).
REQ-024 STABLE: lock_s=1 for STABLE_CYCLES consecutive cycles -> RUN; any lock_s=0 -> WAIT_LOCK with counter cleared, and the timeout budget restarted.
REQ-025 RUN: sys_rst_n=1 from the first RUN cycle; lock_s=0 -> loss_cnt+1 (saturating), sys_rst_n=0 in the same cycle the state leaves RUN, retry_cnt cleared, next state RESET_PLL.
REQ-026 Retry: if retry_cnt==MAX_RETRY-1 -> FAIL, else retry_cnt+1 and RESET_PLL.
REQ-027 FAIL SHALL be terminal until rst_n; pll_rst=1, sys_rst_n=0, fail=1.
REQ-028 retry_cnt SHALL clear on entry to RUN.
REQ-029 Frequency counter: rising edge of mon_s (mon_s=1, previous=0) increments a 16-bit edge counter that saturates at 65535; it runs free in every state.
REQ-030 At the end of every WINDOW cycles: freq_cnt <= edge count including any edge in that final cycle, freq_valid=1 for one cycle, edge counter restarts at 0 (or 1 if an edge falls in the first new cycle).
REQ-031 freq_err SHALL be set only on a freq_valid whose whole window lay in RUN; it clears only on rst_n.
REQ-032 Leaving RUN mid-window SHALL invalidate that window for freq_err checking; freq_cnt still updates.
REQ-033 Lock loss and retry on the same cycle cannot occur (different states); the state transition takes priority over every counter update in that cycle.

Reset
REQ-034 While rst_n=0: state=IDLE, pll_rst=1, sys_rst_n=0, retry_cnt=0, loss_cnt=0, freq_cnt=0, freq_valid=0, freq_err=0, fail=0, synchronizers and counters cleared.
REQ-035 Assertion of rst_n mid-operation SHALL take effect immediately (asynchronous); deassertion is applied synchronously through a 2-flop reset synchronizer on clk_tb.

Verification
REQ-036 Lock rises 500 cycles after pll_rst falls and holds -> STABLE for 64 cycles, RUN, sys_rst_n=1, retry_cnt=0.
REQ-037 Lock never rises -> three timeouts of 4096 cycles, each preceded by a 16-cycle pll_rst pulse, then FAIL, fail=1, retry_cnt=2.
REQ-038 In RUN, lock drops for 10 cycles -> loss_cnt=1, sys_rst_n=0 within 3 cycles of the drop, new 16-cycle pll_rst pulse, recovery to RUN.
REQ-039 Lock glitches low for 1 cycle at STABLE cycle 30 -> return to WAIT_LOCK; RUN reached only after 64 further uninterrupted cycles.
REQ-040 clk_mon period 10 clk_tb cycles in RUN -> freq_cnt=100 every 1000 cycles, freq_err=0; period 8 -> freq_cnt=125, freq_err=1 sticky.
REQ-041 rst_n pulsed low during RUN -> all outputs at REQ-034 values immediately; sequence restarts at IDLE.
